// File: rtl/ddr2_rd_fifo_ctrl.sv
// Pointer, occupancy and credit controller for the 16-entry distributed-RAM
// read-data FIFO in the DDR2 read path. Data itself lives in the RAM array;
// this block only steers addresses/enables and guarantees that every granted
// read burst has room reserved before the command issues.
module ddr2_rd_fifo_ctrl #(
    parameter int unsigned BURST_WORDS  = 2,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic       clk0,
    input  logic       rst0,
    input  logic       cmd_req,
    output logic       cmd_gnt,
    input  logic       wr_en,
    output logic       ram_we,
    output logic [3:0] ram_wa,
    output logic [3:0] ram_ra,
    input  logic       rd_en,
    output logic       rd_valid,
    output logic [4:0] count,
    output logic [4:0] reserved,
    output logic       full,
    output logic       afull,
    output logic       overflow,
    output logic       underflow,
    input  logic       clr_err
);

    localparam logic [5:0] BURST_W6 = 6'(BURST_WORDS);
    localparam logic [5:0] DEPTH_W6 = 6'd16;
    localparam logic [4:0] AFULL_W5 = 5'(AFULL_THRESH);

    logic [3:0] wr_ptr_q, wr_ptr_d;
    logic [3:0] rd_ptr_q, rd_ptr_d;
    logic [4:0] count_q, count_d;
    logic [4:0] pending_q, pending_d;
    logic       overflow_q, overflow_d;
    logic       underflow_q, underflow_d;

    logic [5:0] reserved_sum;
    logic [5:0] pending_sum;
    logic       empty;
    logic       is_full;
    logic       wr_acc;
    logic       rd_acc;
    logic       gnt;

    // Combinational credit, handshake and status outputs.
    always_comb begin
        reserved_sum = {1'b0, count_q} + {1'b0, pending_q};
        empty        = (count_q == '0);
        is_full      = (count_q == 5'd16);
        gnt          = cmd_req & ~rst0 & ((reserved_sum + BURST_W6) <= DEPTH_W6);
        wr_acc       = wr_en & ~is_full & ~rst0;
        rd_acc       = rd_en & ~empty & ~rst0;

        cmd_gnt   = gnt;
        ram_we    = wr_acc;
        ram_wa    = wr_ptr_q;
        ram_ra    = rd_ptr_q;
        rd_valid  = ~empty & ~rst0;
        count     = count_q;
        reserved  = reserved_sum[4:0];
        full      = is_full;
        afull     = (count_q >= AFULL_W5);
        overflow  = overflow_q;
        underflow = underflow_q;
    end

    // Next-state: pointers, occupancy, outstanding credit and sticky errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        pending_sum = {1'b0, pending_q};

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 4'd1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 4'd1;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        // Grant credit is added before the write consumes one, so a grant and
        // a write in the same cycle net to BURST_WORDS-1 even from zero.
        if (gnt) begin
            pending_sum = pending_sum + BURST_W6;
        end
        if (wr_acc && (pending_sum != '0)) begin
            pending_sum = pending_sum - 6'd1;
        end
        pending_d = pending_sum[4:0];

        // A set event in the same cycle as clr_err wins.
        overflow_d  = (overflow_q & ~clr_err) | (wr_en & ((pending_q == '0) | is_full));
        underflow_d = (underflow_q & ~clr_err) | (rd_en & empty);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_ddr2_rd_fifo_ctrl.sv
// Self-checking bench for ddr2_rd_fifo_ctrl: directed scenarios followed by
// randomized traffic, all compared against a transaction-level FIFO model
// that also emulates the RAM16X1D array to check data ordering.
module tb_ddr2_rd_fifo_ctrl;

    localparam int BW = 2;
    localparam int AT = 12;

    logic       clk0 = 1'b0;
    logic       rst0, cmd_req, wr_en, rd_en, clr_err;
    logic       cmd_gnt, ram_we, rd_valid, full, afull, overflow, underflow;
    logic [3:0] ram_wa, ram_ra;
    logic [4:0] count, reserved;
    logic [7:0] din;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model state
    int       m_cnt, m_pend, m_wp, m_rp, m_ovf, m_unf;
    bit       m_valid = 0;
    logic [7:0] data_q[$];
    logic [7:0] ram_mem [16];
    int       gnt_seen;

    ddr2_rd_fifo_ctrl #(.BURST_WORDS(BW), .AFULL_THRESH(AT)) dut (
        .clk0(clk0), .rst0(rst0), .cmd_req(cmd_req), .cmd_gnt(cmd_gnt),
        .wr_en(wr_en), .ram_we(ram_we), .ram_wa(ram_wa), .ram_ra(ram_ra),
        .rd_en(rd_en), .rd_valid(rd_valid), .count(count), .reserved(reserved),
        .full(full), .afull(afull), .overflow(overflow), .underflow(underflow),
        .clr_err(clr_err)
    );

    always #5 clk0 = ~clk0;

    // Emulated distributed RAM: synchronous write, asynchronous read.
    always @(posedge clk0) begin
        if (ram_we) ram_mem[ram_wa] <= din;
    end

    task automatic check(input string tag, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
    task automatic step(input bit r, input bit req, input bit w, input bit rd, input bit clr);
        bit e_gnt, e_we, e_wacc, e_racc;
        int p;
        rst0 = r; cmd_req = req; wr_en = w; rd_en = rd; clr_err = clr;
        din = 8'($urandom);
        @(negedge clk0);
        e_gnt = req && !r && (m_cnt + m_pend + BW <= 16);
        e_we  = w && !r && (m_cnt != 16);
        if (cmd_gnt) gnt_seen++;
        if (m_valid) begin
            check("cmd_gnt", cmd_gnt, e_gnt);
            check("ram_we", ram_we, e_we);
            check("ram_wa", ram_wa, m_wp);
            check("ram_ra", ram_ra, m_rp);
            check("rd_valid", rd_valid, (!r && m_cnt > 0));
            check("count", count, m_cnt);
            check("reserved", reserved, (m_cnt + m_pend) % 32);
            check("full", full, m_cnt == 16);
            check("afull", afull, m_cnt >= AT);
            check("overflow", overflow, m_ovf);
            check("underflow", underflow, m_unf);
            if (!r && rd && m_cnt > 0 && data_q.size() > 0)
                check("rd_data", ram_mem[ram_ra], data_q[0]);
        end
        // Advance the model to the post-edge state.
        if (r) begin
            m_cnt = 0; m_pend = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
            data_q.delete();
            m_valid = 1;
        end else if (m_valid) begin
            e_wacc = e_we;
            e_racc = rd && (m_cnt > 0);
            m_ovf = (m_ovf && !clr) || (w && (m_pend == 0 || m_cnt == 16));
            m_unf = (m_unf && !clr) || (rd && m_cnt == 0);
            if (e_racc) begin void'(data_q.pop_front()); m_rp = (m_rp + 1) % 16; end
            if (e_wacc) begin data_q.push_back(din); m_wp = (m_wp + 1) % 16; end
            m_cnt = m_cnt + int'(e_wacc) - int'(e_racc);
            p = m_pend + (e_gnt ? BW : 0);
            if (e_wacc && p > 0) p--;
            m_pend = p;
        end
        @(posedge clk0);
        #1;
    endtask

    initial begin
        rst0 = 1; cmd_req = 0; wr_en = 0; rd_en = 0; clr_err = 0; din = '0;
        @(posedge clk0); #1;
        step(1, 0, 0, 0, 0);

        // Credit exhaustion: exactly 8 grants of 2 words fill the reservation.
        gnt_seen = 0;
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0);
        check("grant_total", gnt_seen, 8);
        check("reserved_full", reserved, 16);

        // Fill all 16 entries, address wraps to 0.
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
        check("fill_count", count, 16);
        check("wa_wrap", ram_wa, 0);

        // Write while full is dropped and flagged; clr_err clears it.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("ovf_cleared", overflow, 0);

        // Full with simultaneous write and read: write dropped, count 15.
        step(0, 0, 1, 1, 0);
        check("full_wr_rd", count, 15);
        step(0, 0, 0, 0, 1);

        // Drain, then read empty; then write without credit.
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("underflow_set", underflow, 1);
        step(0, 0, 1, 0, 1);
        check("nocredit_ovf", overflow, 1);
        check("nocredit_cnt", count, 1);

        // count=5, pending=1, simultaneous write+read.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        check("wr_rd_count", count, 5);
        check("wr_rd_reserved", reserved, 5);

        // Empty FIFO with same-cycle write and read: count becomes 1.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        check("empty_wr_rd", count, 1);

        // Mid-burst reset: count=6, pending=3, all inputs high during reset.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        check("mid_count", count, 6);
        check("mid_reserved", reserved, 9);
        step(1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        check("post_rst_count", count, 0);
        check("post_rst_reserved", reserved, 0);

        // Randomized traffic in phases with differing read pressure.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 500; i++) begin
                bit rq, w, rd, c, r;
                rq = ($urandom_range(99) < 50);
                w  = (m_pend > 0) ? ($urandom_range(99) < 70) : ($urandom_range(99) < 3);
                rd = ($urandom_range(99) < ((ph % 2) ? 15 : 55));
                c  = ($urandom_range(99) < 4);
                r  = ($urandom_range(999) < 5);
                step(r, rq, w, rd, c);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ddr2_rd_fifo_ctrl.md
Name: ddr2_rd_fifo_ctrl

Overview:
Pointer, occupancy and credit controller for the 16-entry distributed-RAM read-data FIFO in the DDR2 read datapath (the MEMORY_WIDTH-wide RAM16X1D array).
- Drives the RAM write address/enable and read address. Data stays in the RAM datapath.
- Tracks occupancy and gives first-word-fall-through read semantics.
- Grants read-command issue only when the FIFO has space reserved for the whole returning burst, so captured read data can never overrun the RAM.

Parameters:
BURST_WORDS, 2, FIFO words returned per granted read command (legal 1..8).
AFULL_THRESH, 12, occupancy at or above which afull asserts (legal 1..16).

Ports:
clk0  in  1  controller clock (RAM write clock).
rst0  in  1  synchronous active-high reset.
cmd_req  in  1  scheduler requests to issue one read burst command.
cmd_gnt  out  1  read command may issue this cycle; combinational from cmd_req and registered state.
wr_en  in  1  one captured read-data word presented to RAM d this cycle.
ram_we  out  1  RAM write enable.
ram_wa  out  4  RAM write address (bit0..3 to a0..a3).
ram_ra  out  4  RAM read address (bit0..3 to dpra0..3).
rd_en  in  1  consumer pops head word.
rd_valid  out  1  head word valid on RAM dpo (FWFT).
count  out  5  stored words, 0..16.
reserved  out  5  count plus words still expected from granted bursts, 0..16.
full  out  1  count==16.
afull  out  1  count>=AFULL_THRESH.
overflow  out  1  sticky: write with no pending credit, or write while full.
underflow  out  1  sticky: rd_en while empty.
clr_err  in  1  clears overflow and underflow.

Behaviour:
- State registers: wr_ptr[3:0], rd_ptr[3:0], count[4:0], pending[4:0], overflow, underflow.
- Reset (rst0=1 at edge): all state registers 0. Outputs after reset: cmd_gnt=0, ram_we=0, ram_wa=0, ram_ra=0, rd_valid=0, count=0, reserved=0, full=0, afull=0, overflow=0, underflow=0.
- While rst0=1, cmd_gnt, ram_we and rd_valid are forced 0. Reset mid-burst discards all stored data and pending credit.
- Credit:
  - reserved = count + pending.
  - cmd_gnt = cmd_req & ~rst0 & (reserved + BURST_WORDS <= 16).
  - On a grant, pending += BURST_WORDS.
- Write:
  - ram_we = wr_en & ~full & ~rst0; ram_wa = wr_ptr.
  - The RAM writes at the clk0 edge. wr_ptr increments mod 16 (15 wraps to 0).
  - An accepted write decrements pending by 1, saturating at 0.
  - wr_en with pending==0 sets overflow; the word is still accepted if not full.
  - wr_en while full sets overflow; the word is dropped and no pointer or count changes.
- Read:
  - ram_ra = rd_ptr; rd_valid = (count!=0).
  - Read data is valid on dpo in the same cycle (asynchronous RAM read).
  - rd_en & rd_valid: rd_ptr increments mod 16.
  - rd_en & ~rd_valid: sets underflow; no change.
- Count update: count' = count + accepted_write - accepted_read.
  - Simultaneous accepted write and read leaves count unchanged.
  - At count==0, a same-cycle write and rd_en: the write is accepted, the read is an underflow, so count becomes 1.
  - At count==16, a same-cycle wr_en and read: the write is dropped (full evaluated pre-edge), the read is accepted, so count becomes 15.
- Simultaneous grant and write: pending' = pending + BURST_WORDS - 1.
- Invariant: reserved <= 16 whenever no overflow has occurred.
- Error flags: overflow and underflow set on their events and clear on clr_err. A set event in the same cycle as clr_err wins.
- Latency:
  - cmd_gnt: 0 cycles.
  - Write to rd_valid: 1 cycle (visible after the write edge).
  - count, reserved and flags: update at the edge following the event.

Test Plan:
- Reset, then cmd_req held high with BURST_WORDS=2 and no wr_en → cmd_gnt high for exactly 8 cycles; reserved=16, count=0; 9th request sees cmd_gnt=0.
- After 8 grants, wr_en for 16 cycles → ram_wa 0..15 then wraps to 0; count=16, full=1, afull=1 from count 12; pending=0; overflow=0.
- count=5 with pending=1, wr_en and rd_en in the same cycle → count stays 5, wr_ptr and rd_ptr each +1, pending=0.
- Full FIFO, wr_en=1 → ram_we=0, overflow=1, count=16. Then clr_err=1 for one cycle → overflow=0.
- Empty FIFO, rd_en=1 → underflow=1, rd_ptr unchanged, rd_valid=0. Also wr_en with pending=0 on a non-full FIFO → word accepted, overflow=1.
- Mid-burst (count=6, pending=3), rst0=1 for one cycle with cmd_req, wr_en and rd_en all high → cmd_gnt=0 and ram_we=0 during reset; afterwards all counters and pointers are 0 and rd_valid=0.
